mux_arbitro_rr: RTL and testbench
=================================

MUX_ARBITRO_RR -- requirements
Module: mux_arbitro_rr

Interface
REQ-001 Parameter WIDTH, default 32, data width per input in bits.
REQ-002 Parameter N, default 4, input channel count; legal range 2..16.
REQ-003 Parameter MODE, default 0, where 0 = key-selected and 1 = round-robin arbitration.
REQ-004 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port entrada  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port entrada_valid  input  N  per-channel valid.
REQ-008 Port entrada_ready  output  N  per-channel ready; combinational; at most one bit high.
REQ-009 Port key  input  SW  channel select, used in MODE 0 only; SW = max(1, clog2(N)).
REQ-010 Port saida  output  WIDTH  registered output data.
REQ-011 Port saida_valid  output  1  output register holds a word.
REQ-012 Port saida_ready  input  1  downstream accepts the word.
REQ-013 Port saida_origem  output  SW  index of the channel that produced saida.

Function
REQ-014 The block shall hold a single-entry output register; it is free when saida_valid=0 or saida_ready=1.
REQ-015 In MODE 0, the grant shall be the channel key when key<N and entrada_valid[key]=1; otherwise there is no grant.
REQ-016 In MODE 1, the grant shall be the first valid channel searched upward from pointer ptr, wrapping N-1 to 0; there is no grant when no channel is valid.
REQ-017 entrada_ready[g] shall be 1 only when g is granted and the register is free; all other ready bits shall be 0.
REQ-018 A transfer on channel g (valid and ready both high) shall load saida=entrada[g] and saida_origem=g and set saida_valid=1 on the next edge; latency is 1 cycle.
REQ-019 When saida_valid=1, saida_ready=1 and no transfer occurs, saida_valid shall clear on the next edge.
REQ-020 When saida_valid=1, saida_ready=1 and a transfer occurs, the register shall reload in the same edge; sustained throughput is 1 word/cycle.
REQ-021 When saida_valid=1 and saida_ready=0, saida and saida_origem shall hold stable and all entrada_ready bits shall be 0.
REQ-022 In MODE 1, each transfer from channel g shall set ptr to (g+1) mod N, with an explicit wrap for non-power-of-2 N; ptr shall not change without a transfer.
REQ-023 In MODE 0, ptr shall be unused and held at 0.
REQ-024 With every channel continuously valid in MODE 1, grants shall rotate 0,1,...,N-1,0; no channel waits more than N-1 transfers.
REQ-025 A channel dropping valid while not granted shall have no effect on state.

Reset
REQ-026 On reset_n=0, the block shall immediately force saida=0, saida_valid=0, saida_origem=0 and ptr=0, regardless of clock.
REQ-027 While reset_n=0, every entrada_ready bit shall be 0.
REQ-028 A word held when reset asserts mid-operation shall be discarded.
REQ-029 The first grant after reset release shall occur no earlier than the first rising edge with reset_n=1.

Structure
REQ-030 A shared package shall hold the MODE constants MODO_KEY=0 and MODO_RR=1 and the select-width function SW.
REQ-031 Round-robin priority selection shall be one sub-module, arbitro_rr (inputs: request vector, ptr; outputs: grant index, grant_valid), instantiated only when MODE=1.
REQ-032 The block shall contain no latches; the combinational grant path shall be fully assigned for every input value.

Verification
REQ-033 MODE 0, N=4, key=2, entrada_valid=4'b0100, channel 2 data 32'hDEADBEEF, saida_ready=1 -> next cycle saida=32'hDEADBEEF, saida_origem=2, saida_valid=1.
REQ-034 MODE 0, key=1, entrada_valid=4'b1101 -> entrada_ready=0 every cycle and saida_valid stays 0.
REQ-035 MODE 1, N=4, all channels valid with data 10,20,30,40, saida_ready=1 for 8 cycles -> saida sequence 10,20,30,40,10,20,30,40 and saida_origem sequence 0,1,2,3,0,1,2,3.
REQ-036 MODE 1, N=3, only channel 2 valid, then all valid -> origins 2,0,1,2, confirming the wrap from 2 to 0.
REQ-037 Backpressure: saida_ready=0 for 5 cycles with saida_valid=1 -> saida is unchanged, entrada_ready=0, and no word is lost or duplicated once saida_ready returns to 1.
REQ-038 reset_n pulsed low between clock edges while saida_valid=1 -> saida_valid=0 and saida=0 immediately; in MODE 1 the first post-reset grant goes to the lowest valid channel at or above 0.

Source files
------------

// File: rtl/mux_arbitro_rr_pkg.sv
// Shared constants for the mux_arbitro_rr block: arbitration mode codes and
// the channel-select width helper.
package mux_arbitro_rr_pkg;

  localparam int MODO_KEY = 0;
  localparam int MODO_RR  = 1;

  // Select width: enough bits to index N channels, never less than one.
  function automatic int sw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arbitro_rr_arbitro.sv
// Round-robin priority selector: picks the first asserted request searching
// upward from ptr and wrapping from N-1 back to 0.
module arbitro_rr #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);

  logic [SW:0] idx;

  // Walk offsets from farthest to nearest so the nearest valid request wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(N)) begin
        idx = idx - (SW+1)'(N);
      end
      if (req[idx[SW-1:0]]) begin
        grant       = idx[SW-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbitro_rr.sv
// N-to-1 multiplexer with a single-entry registered output; the source channel
// is chosen either by an external key or by a round-robin arbiter.
module mux_arbitro_rr
  import mux_arbitro_rr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = MODO_KEY
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N*WIDTH-1:0]   entrada,
  input  logic [N-1:0]         entrada_valid,
  output logic [N-1:0]         entrada_ready,
  input  logic [sw(N)-1:0]     key,
  output logic [WIDTH-1:0]     saida,
  output logic                 saida_valid,
  input  logic                 saida_ready,
  output logic [sw(N)-1:0]     saida_origem
);

  localparam int SW = sw(N);
  localparam int NP = 1 << SW;

  logic [WIDTH-1:0] canal [NP];
  logic [NP-1:0]    valid_ext;
  logic [SW-1:0]    grant;
  logic             grant_valid;
  logic             free;
  logic             transfer;

  // Pad the channel view to a power of two so any select value indexes safely.
  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_canal
      if (gi < N) begin : g_real
        assign canal[gi] = entrada[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign canal[gi] = '0;
      end
    end
  endgenerate

  assign valid_ext = NP'(entrada_valid);

  generate
    if (MODE == MODO_RR) begin : g_rr
      logic [SW-1:0] ptr;

      arbitro_rr #(
        .N  (N),
        .SW (SW)
      ) u_arbitro (
        .req         (entrada_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
      );

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          ptr <= '0;
        end else if (transfer) begin
          ptr <= (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
        end
      end
    end else begin : g_key
      assign grant       = key;
      assign grant_valid = (int'(key) < N) && valid_ext[key];
    end
  endgenerate

  assign free     = !saida_valid || saida_ready;
  assign transfer = grant_valid && free;

  // Ready is gated by reset_n so no handshake is offered while held in reset.
  always_comb begin
    entrada_ready = '0;
    if (transfer && reset_n) begin
      entrada_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      saida        <= '0;
      saida_valid  <= 1'b0;
      saida_origem <= '0;
    end else if (transfer) begin
      saida        <= canal[grant];
      saida_valid  <= 1'b1;
      saida_origem <= grant;
    end else if (saida_ready) begin
      saida_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbitro_rr.sv
// Directed bench for mux_arbitro_rr: key mode (N=4), round-robin (N=4, N=3),
// backpressure and asynchronous reset.
module tb_mux_arbitro_rr;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // Key mode, N=4
  logic [127:0] e0;
  logic [3:0]   v0, r0;
  logic [1:0]   k0, so0;
  logic [31:0]  s0;
  logic         sv0, sr0;
  // Round-robin, N=4
  logic [127:0] e1;
  logic [3:0]   v1, r1;
  logic [1:0]   k1, so1;
  logic [31:0]  s1;
  logic         sv1, sr1;
  // Round-robin, N=3
  logic [95:0]  e2;
  logic [2:0]   v2, r2;
  logic [1:0]   k2, so2;
  logic [31:0]  s2;
  logic         sv2, sr2;

  int checks = 0;
  int failures = 0;

  mux_arbitro_rr #(.WIDTH(32), .N(4), .MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .entrada(e0), .entrada_valid(v0),
    .entrada_ready(r0), .key(k0), .saida(s0), .saida_valid(sv0),
    .saida_ready(sr0), .saida_origem(so0));

  mux_arbitro_rr #(.WIDTH(32), .N(4), .MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .entrada(e1), .entrada_valid(v1),
    .entrada_ready(r1), .key(k1), .saida(s1), .saida_valid(sv1),
    .saida_ready(sr1), .saida_origem(so1));

  mux_arbitro_rr #(.WIDTH(32), .N(3), .MODE(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .entrada(e2), .entrada_valid(v2),
    .entrada_ready(r2), .key(k2), .saida(s2), .saida_valid(sv2),
    .saida_ready(sr2), .saida_origem(so2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    e0 = '0; v0 = '0; k0 = '0; sr0 = 1'b0;
    e1 = '0; v1 = '0; k1 = '0; sr1 = 1'b0;
    e2 = '0; v2 = '0; k2 = '0; sr2 = 1'b0;

    // Reset state, and no ready while reset is held even with valid requests
    v1 = 4'hF;
    repeat (2) tick();
    chk("rst_sv0", 64'(sv0), 64'(1'b0));
    chk("rst_s0", 64'(s0), 64'(32'h0));
    chk("rst_so0", 64'(so0), 64'(2'd0));
    chk("rst_r1", 64'(r1), 64'(4'h0));
    v1 = 4'h0;
    reset_n = 1'b1;

    // Key mode: key=2 selects channel 2
    e0 = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    k0 = 2'd2; v0 = 4'b0100; sr0 = 1'b1;
    #1;
    chk("key_r0", 64'(r0), 64'(4'b0100));
    tick();
    chk("key_s0", 64'(s0), 64'(32'hDEADBEEF));
    chk("key_so0", 64'(so0), 64'(2'd2));
    chk("key_sv0", 64'(sv0), 64'(1'b1));
    v0 = 4'b0000;
    tick();
    chk("key_drain_sv0", 64'(sv0), 64'(1'b0));

    // Key mode: selected channel not valid -> no grant
    k0 = 2'd1; v0 = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nokey_r0", 64'(r0), 64'(4'h0));
      tick();
      chk("nokey_sv0", 64'(sv0), 64'(1'b0));
    end
    v0 = 4'b0000;

    // Round-robin N=4: all valid, rotation 0..3 twice
    e1 = {32'd40, 32'd30, 32'd20, 32'd10};
    v1 = 4'hF; sr1 = 1'b1;
    #1;
    chk("rr_first_r1", 64'(r1), 64'(4'b0001));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_s1", 64'(s1), 64'((i % 4 + 1) * 10));
      chk("rr_so1", 64'(so1), 64'(i % 4));
    end

    // Backpressure: word 40 held, no ready offered
    sr1 = 1'b0;
    #1;
    chk("bp_r1", 64'(r1), 64'(4'h0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_s1", 64'(s1), 64'(32'd40));
      chk("bp_so1", 64'(so1), 64'(2'd3));
      chk("bp_r1_hold", 64'(r1), 64'(4'h0));
    end
    sr1 = 1'b1;
    tick();
    chk("bp_resume_s1", 64'(s1), 64'(32'd10));
    tick();
    chk("bp_next_s1", 64'(s1), 64'(32'd20));
    v1 = 4'h0;
    tick();
    chk("rr_idle_sv1", 64'(sv1), 64'(1'b0));

    // Reset mid-cycle with a word held; ptr would otherwise point at 3
    v1 = 4'b1100; sr1 = 1'b0;
    tick();
    chk("pre_rst_so1", 64'(so1), 64'(2'd2));
    chk("pre_rst_sv1", 64'(sv1), 64'(1'b1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_sv1", 64'(sv1), 64'(1'b0));
    chk("async_s1", 64'(s1), 64'(32'h0));
    chk("async_so1", 64'(so1), 64'(2'd0));
    chk("async_r1", 64'(r1), 64'(4'h0));
    reset_n = 1'b1;
    sr1 = 1'b1;
    #0.5;
    chk("post_rst_r1", 64'(r1), 64'(4'b0100));
    tick();
    chk("post_rst_so1", 64'(so1), 64'(2'd2));
    chk("post_rst_s1", 64'(s1), 64'(32'd30));
    v1 = 4'h0;

    // Round-robin N=3: wrap from 2 to 0
    e2 = {32'd102, 32'd101, 32'd100};
    sr2 = 1'b1; v2 = 3'b100;
    tick();
    chk("n3_so2_a", 64'(so2), 64'(2'd2));
    v2 = 3'b111;
    tick();
    chk("n3_so2_b", 64'(so2), 64'(2'd0));
    tick();
    chk("n3_so2_c", 64'(so2), 64'(2'd1));
    tick();
    chk("n3_so2_d", 64'(so2), 64'(2'd2));
    chk("n3_s2_d", 64'(s2), 64'(32'd102));
    tick();
    chk("n3_so2_e", 64'(so2), 64'(2'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
